// File: rtl/ram_stream_fifo_ctrl.sv
// Valid/ready FIFO controller driving a 1-write/1-read synchronous RAM; the RAM output
// register acts as the head slot, so the FIFO holds 2**addressWidth + 1 words in total.
module ram_stream_fifo_ctrl #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [dataWidth-1:0]    push_data,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [dataWidth-1:0]    pop_data,
  output logic [addressWidth:0]   occupancy,
  output logic                    ram_wr_en,
  output logic                    ram_wr_mask,
  output logic [addressWidth-1:0] ram_wr_addr,
  output logic [dataWidth-1:0]    ram_wr_data,
  output logic                    ram_rd_en,
  output logic [addressWidth-1:0] ram_rd_addr,
  input  logic [dataWidth-1:0]    ram_rd_data
);

  localparam int                      DEPTH    = 2 ** addressWidth;
  localparam logic [addressWidth:0]   CNT_FULL = (addressWidth + 1)'(DEPTH);
  localparam logic [addressWidth:0]   CNT_ZERO = (addressWidth + 1)'(0);
  localparam logic [addressWidth:0]   CNT_ONE  = (addressWidth + 1)'(1);
  localparam logic [addressWidth-1:0] PTR_ZERO = addressWidth'(0);
  localparam logic [addressWidth-1:0] PTR_ONE  = addressWidth'(1);

  logic [addressWidth-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [addressWidth:0]   ram_cnt_r, ram_cnt_nxt_s;
  logic [addressWidth:0]   occupancy_r, occupancy_nxt_s;
  logic                    pop_valid_r, pop_valid_nxt_s;
  logic                    clear_s, push_fire_s, rd_issue_s;

  // Handshake decode and next-state computation
  always_comb begin
    clear_s         = reset | flush;
    push_ready      = 1'b0;
    push_fire_s     = 1'b0;
    rd_issue_s      = 1'b0;
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    ram_cnt_nxt_s   = ram_cnt_r;
    pop_valid_nxt_s = pop_valid_r;

    if (clear_s) begin
      wr_ptr_nxt_s    = PTR_ZERO;
      rd_ptr_nxt_s    = PTR_ZERO;
      ram_cnt_nxt_s   = CNT_ZERO;
      pop_valid_nxt_s = 1'b0;
    end else begin
      push_ready  = (ram_cnt_r != CNT_FULL);
      push_fire_s = push_valid & push_ready;
      // A read is only issued when the output register is free or being drained,
      // which keeps rd_data frozen during a stall.
      rd_issue_s  = (ram_cnt_r != CNT_ZERO) & (~pop_valid_r | pop_ready);

      wr_ptr_nxt_s    = push_fire_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_nxt_s    = rd_issue_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      pop_valid_nxt_s = rd_issue_s | (pop_valid_r & ~pop_ready);

      case ({push_fire_s, rd_issue_s})
        2'b10:   ram_cnt_nxt_s = ram_cnt_r + CNT_ONE;
        2'b01:   ram_cnt_nxt_s = ram_cnt_r - CNT_ONE;
        default: ram_cnt_nxt_s = ram_cnt_r;
      endcase
    end

    occupancy_nxt_s = ram_cnt_nxt_s + {{addressWidth{1'b0}}, pop_valid_nxt_s};
  end

  // State registers; reset and flush share the clear path
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      ram_cnt_r   <= CNT_ZERO;
      occupancy_r <= CNT_ZERO;
      pop_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      ram_cnt_r   <= ram_cnt_nxt_s;
      occupancy_r <= occupancy_nxt_s;
      pop_valid_r <= pop_valid_nxt_s;
    end
  end

  assign pop_valid   = pop_valid_r;
  assign pop_data    = ram_rd_data;
  assign occupancy   = occupancy_r;
  assign ram_wr_en   = push_fire_s;
  assign ram_wr_mask = 1'b1;
  assign ram_wr_addr = wr_ptr_r;
  assign ram_wr_data = push_data;
  assign ram_rd_en   = rd_issue_s;
  assign ram_rd_addr = rd_ptr_r;

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Bench for ram_stream_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_ram_stream_fifo_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data, ram_wr_data, ram_rd_data;
  logic [AW:0]   occupancy;
  logic          ram_wr_en, ram_wr_mask, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  ram_stream_fifo_ctrl #(.addressWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .occupancy(occupancy),
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  // Ram_1w_1rs behaviour: synchronous write, registered read
  always @(posedge clk) begin
    if (ram_wr_en && ram_wr_mask) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Advance one clock and update the FIFO model from the handshakes seen this cycle
  task automatic tick();
    bit            pf, pp, clr;
    logic [DW-1:0] pd, dropped;
    pf  = push_valid && push_ready;
    pp  = pop_valid && pop_ready;
    clr = reset || flush;
    pd  = push_data;
    @(posedge clk);
    if (clr) exp_q.delete();
    else begin
      if (pp && exp_q.size() > 0) dropped = exp_q.pop_front();
      if (pf) exp_q.push_back(pd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; push_valid = 1'b1; pop_ready = 1'b1; push_data = 32'h12345678;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL reset_push_ready: got %b want 0", push_ready); end
      n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
      n_checks++; if ({ram_wr_en, ram_rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b want 00", {ram_wr_en, ram_rd_en}); end
      n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      tick();
    end
    reset = 1'b0; push_valid = 1'b0;
    #1;
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL release_push_ready: got %b want 1", push_ready); end
    n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL release_occupancy: got %0d want 0", occupancy); end
    n_checks++; if (ram_wr_mask !== 1'b1) begin n_fail++; $display("FAIL wr_mask: got %b want 1", ram_wr_mask); end
    n_checks++; if ({ram_wr_addr, ram_rd_addr} !== 10'd0) begin n_fail++; $display("FAIL release_ptrs: got %h want 0", {ram_wr_addr, ram_rd_addr}); end
    tick();
  endtask

  task automatic test_latency();
    push_valid = 1'b1; push_data = 32'hA5A5A5A5; pop_ready = 1'b1;
    #1;
    n_checks++; if (ram_wr_en !== 1'b1 || ram_wr_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lat_write: got en=%b data=%h want en=1 data=a5a5a5a5", ram_wr_en, ram_wr_data); end
    n_checks++; if (ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL lat_rd_t0: got %b want 0", ram_rd_en); end
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (ram_rd_en !== 1'b1 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL lat_rd_t1: got rd_en=%b pop_valid=%b want 1,0", ram_rd_en, pop_valid); end
    n_checks++; if (occupancy !== 6'd1) begin n_fail++; $display("FAIL lat_occ_t1: got %0d want 1", occupancy); end
    tick();
    #1;
    n_checks++; if (pop_valid !== 1'b1 || pop_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lat_pop_t2: got valid=%b data=%h want 1 a5a5a5a5", pop_valid, pop_data); end
    tick();
    #1;
    n_checks++; if (occupancy !== 6'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got occ=%0d valid=%b want 0,0", occupancy, pop_valid); end
  endtask

  task automatic test_fill();
    int  exp_val;
    bit  pushed_last;
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      push_data = 32'(i);
      #1;
      n_checks++; if (push_ready !== (i < 33)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want %b", i, push_ready, (i < 33)); end
      tick();
    end
    #1;
    n_checks++; if (occupancy !== 6'd33 || push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got occ=%0d ready=%b want 33,0", occupancy, push_ready); end
    tick();
    pop_ready = 1'b1; exp_val = 0; pushed_last = 1'b0;
    for (int c = 0; c < 100 && exp_val < 34; c++) begin
      push_valid = !pushed_last; push_data = 32'd33;
      #1;
      if (c == 0) begin
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_first_pop_ready: got %b want 0", push_ready); end
      end
      if (c == 1) begin
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL fill_after_pop_ready: got %b want 1", push_ready); end
      end
      if (push_valid && push_ready) pushed_last = 1'b1;
      if (pop_valid) begin
        n_checks++; if (pop_data !== 32'(exp_val)) begin n_fail++; $display("FAIL fill_order: got %0d want %0d", pop_data, exp_val); end
        exp_val++;
      end
      tick();
    end
    push_valid = 1'b0;
    #1;
    n_checks++; if (exp_val !== 34 || occupancy !== 6'd0) begin n_fail++; $display("FAIL fill_drain: got popped=%0d occ=%0d want 34,0", exp_val, occupancy); end
  endtask

  task automatic test_wrap();
    int sent = 0, rcvd = 0;
    for (int c = 0; c < 3000 && rcvd < 100; c++) begin
      push_valid = (sent < 100) && ($urandom_range(0, 1) == 1);
      push_data  = $urandom;
      pop_ready  = ($urandom_range(0, 1) == 1);
      #1;
      n_checks++; if (occupancy !== 6'(exp_q.size())) begin n_fail++; $display("FAIL wrap_occ: got %0d want %0d", occupancy, exp_q.size()); end
      if (ram_wr_en && ram_rd_en) begin
        n_checks++; if (ram_rd_addr === ram_wr_addr) begin n_fail++; $display("FAIL wrap_collision: got rd=%0d wr=%0d want distinct", ram_rd_addr, ram_wr_addr); end
      end
      if (pop_valid && pop_ready) begin
        n_checks++; if (exp_q.size() == 0 || pop_data !== exp_q[0]) begin n_fail++; $display("FAIL wrap_data: got %h want %h", pop_data, (exp_q.size() > 0) ? exp_q[0] : 32'hX); end
        rcvd++;
      end
      if (push_valid && push_ready) sent++;
      tick();
    end
    push_valid = 1'b0;
    n_checks++; if (rcvd !== 100) begin n_fail++; $display("FAIL wrap_count: got %0d want 100", rcvd); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = $urandom;
      #1; tick();
    end
    push_valid = 1'b0;
    for (int c = 0; c < 5 && !pop_valid; c++) begin #1; tick(); end
    #1;
    held = pop_data;
    n_checks++; if (pop_valid !== 1'b1 || exp_q.size() == 0 || held !== exp_q[0]) begin n_fail++; $display("FAIL bp_head: got valid=%b data=%h want 1 %h", pop_valid, held, (exp_q.size() > 0) ? exp_q[0] : 32'hX); end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (pop_valid !== 1'b1 || pop_data !== held || ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall[%0d]: got valid=%b data=%h rd_en=%b want 1 %h 0", c, pop_valid, pop_data, ram_rd_en, held); end
      tick();
    end
    pop_ready = 1'b1;
    for (int c = 0; c < 20 && occupancy != 6'd0; c++) begin
      #1;
      if (pop_valid) begin
        n_checks++; if (exp_q.size() == 0 || pop_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_drain: got %h want %h", pop_data, (exp_q.size() > 0) ? exp_q[0] : 32'hX); end
      end
      tick();
    end
    #1;
    n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL bp_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    int got = 0;
    pop_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_valid = 1'b1; push_data = 32'h100 + 32'(i);
      #1; tick();
    end
    push_valid = 1'b0;
    #1;
    n_checks++; if (occupancy !== 6'd7) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 7", occupancy); end
    flush = 1'b1; push_valid = 1'b1; push_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (push_ready !== 1'b0 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_block: got ready=%b wr=%b rd=%b want 0,0,0", push_ready, ram_wr_en, ram_rd_en); end
    tick();
    flush = 1'b0; push_valid = 1'b0;
    #1;
    n_checks++; if (occupancy !== 6'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got occ=%0d valid=%b want 0,0", occupancy, pop_valid); end
    push_valid = 1'b1; push_data = 32'h1; pop_ready = 1'b1;
    tick();
    push_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (pop_valid) begin
        n_checks++; if (pop_data !== 32'h1) begin n_fail++; $display("FAIL flush_repush: got %h want 1", pop_data); end
        got++;
      end
      tick();
    end
    n_checks++; if (got !== 1 || occupancy !== 6'd0) begin n_fail++; $display("FAIL flush_repush_count: got pops=%0d occ=%0d want 1,0", got, occupancy); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_fill();
    test_wrap();
    test_backpressure();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
